// File: rtl/vga_pkg.sv
// Shared timing defaults, total-length helper and the sync bundle carried by the delay line.
// Defaults describe 640x480@60 on a 25.175 MHz pixel clock.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Same formula serves both axes: visible + front porch + sync + back porch.
   function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

endpackage

// File: rtl/sync_delay.sv
// Purpose: DEPTH-stage shift register of sync_t with a programmable idle value.
// Latency: DEPTH enabled clocks from d to q.
// Backpressure: none; en low freezes every stage.
module sync_delay
   import vga_pkg::*;
#(
   parameter int    DEPTH = 1,
   parameter sync_t IDLE  = '0
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  sync_t d,
   output sync_t q
);

   sync_t stg [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= IDLE;
         end
      end else if (en) begin
         stg[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster counters, sync/active decode and line/frame strobes.
// Latency: counters and strobes undelayed; hsync/vsync/valid lag the counters by PIPE_DLY enabled clocks.
// Backpressure: none; en low holds all state and forces the strobes low.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 1,
   parameter int CW       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [CW-1:0] col_count,
   output logic [CW-1:0] row_count,
   output logic          hsync,
   output logic          vsync,
   output logic          valid,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_count
);

   localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_chk_dly
      $fatal(1, "vga_timing_gen: PIPE_DLY must be within 1..8");
   end
   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_porch
      $fatal(1, "vga_timing_gen: porch and sync widths must be non-zero");
   end
   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_chk_cw
      $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end

   // Every threshold below is strictly less than its total, so CW bits always hold it.
   localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_E = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_E = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

   localparam sync_t SYNC_IDLE = sync_t'({~HS_POL, ~VS_POL, 1'b0});

   logic  col_wrap;
   logic  row_wrap;
   sync_t raw;
   sync_t dly;

   assign col_wrap = (col_count == H_LAST);
   assign row_wrap = (row_count == V_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_count   <= '0;
         row_count   <= '0;
         frame_count <= '0;
      end else if (en) begin
         if (col_wrap) begin
            col_count <= '0;
            if (row_wrap) begin
               row_count   <= '0;
               frame_count <= frame_count + 8'd1;
            end else begin
               row_count <= row_count + 1'b1;
            end
         end else begin
            col_count <= col_count + 1'b1;
         end
      end
   end

   // Sync levels enter the delay line already polarity-adjusted, so the outputs are plain flops.
   always_comb begin
      raw     = SYNC_IDLE;
      raw.act = (col_count < H_ACT_E) && (row_count < V_ACT_E);
      raw.hs  = ((col_count >= HS_BEG) && (col_count < HS_END)) ? HS_POL : ~HS_POL;
      raw.vs  = ((row_count >= VS_BEG) && (row_count < VS_END)) ? VS_POL : ~VS_POL;
   end

   sync_delay #(
      .DEPTH (PIPE_DLY),
      .IDLE  (SYNC_IDLE)
   ) u_sync_delay (
      .clk   (clk),
      .rst_n (reset),
      .en    (en),
      .d     (raw),
      .q     (dly)
   );

   assign hsync = dly.hs;
   assign vsync = dly.vs;
   assign valid = dly.act;

   // Strobes are gated by reset as well so they read low while reset is held.
   assign line_start  = reset && en && (col_count == '0);
   assign frame_start = line_start && (row_count == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generators share clk/reset/en: tiny raster (A), tiny raster with 4-deep delay and
// inverted polarity (B), default 640x480 raster (C); a negedge monitor scores all of them.
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic       hs;
      logic       vs;
      logic       vld;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   typedef struct packed {
      logic [7:0]  tag;
      logic [31:0] val;
   } dchk_t;

   localparam logic [7:0] T_MARK = 0, T_MEAS_ON = 1, T_MEAS_OFF = 2, T_A_COL = 3, T_A_ROW = 4,
                          T_A_FC = 5, T_A_VLD_CNT = 6, T_A_FS_CNT = 7, T_B_HS = 8, T_B_VS = 9,
                          T_B_RISE = 10, T_C_COL = 11, T_C_ROW = 12, T_C_HS = 13, T_STRB_CNT = 14,
                          T_SB_EMPTY = 15;

   int g_ha[3]  = '{8, 8, 640};
   int g_hf[3]  = '{2, 2, 16};
   int g_hs[3]  = '{2, 2, 96};
   int g_hb[3]  = '{2, 2, 48};
   int g_va[3]  = '{4, 4, 480};
   int g_vf[3]  = '{1, 1, 10};
   int g_vs[3]  = '{1, 1, 2};
   int g_vb[3]  = '{1, 1, 33};
   int g_dly[3] = '{1, 4, 1};
   bit g_hp[3]  = '{1'b0, 1'b1, 1'b0};
   bit g_vp[3]  = '{1'b0, 1'b1, 1'b0};

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [9:0] col_q [3];
   logic [9:0] row_q [3];
   logic       hs_q  [3];
   logic       vs_q  [3];
   logic       vld_q [3];
   logic       ls_q  [3];
   logic       fs_q  [3];
   logic [7:0] fc_q  [3];

   int         m_col [3];
   int         m_row [3];
   int         m_fc  [3];
   logic [2:0] m_hist [3][8];

   obs_t  sb_q[$];
   dchk_t dq[$];

   int n_chk  = 0;
   int n_fail = 0;

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(1), .CW(10)) u_a (
      .clk(clk), .reset(rst_n), .en(en), .col_count(col_q[0]), .row_count(row_q[0]),
      .hsync(hs_q[0]), .vsync(vs_q[0]), .valid(vld_q[0]), .line_start(ls_q[0]),
      .frame_start(fs_q[0]), .frame_count(fc_q[0]));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(4), .CW(10)) u_b (
      .clk(clk), .reset(rst_n), .en(en), .col_count(col_q[1]), .row_count(row_q[1]),
      .hsync(hs_q[1]), .vsync(vs_q[1]), .valid(vld_q[1]), .line_start(ls_q[1]),
      .frame_start(fs_q[1]), .frame_count(fc_q[1]));

   vga_timing_gen #(.PIPE_DLY(1), .CW(10)) u_c (
      .clk(clk), .reset(rst_n), .en(en), .col_count(col_q[2]), .row_count(row_q[2]),
      .hsync(hs_q[2]), .vsync(vs_q[2]), .valid(vld_q[2]), .line_start(ls_q[2]),
      .frame_start(fs_q[2]), .frame_count(fc_q[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [2:0] raw_of(int i);
      logic h, v, a;
      h = (m_col[i] >= g_ha[i] + g_hf[i]) && (m_col[i] < g_ha[i] + g_hf[i] + g_hs[i]);
      v = (m_row[i] >= g_va[i] + g_vf[i]) && (m_row[i] < g_va[i] + g_vf[i] + g_vs[i]);
      a = (m_col[i] < g_ha[i]) && (m_row[i] < g_va[i]);
      return {h, v, a};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_col[i] = 0;
         m_row[i] = 0;
         m_fc[i]  = 0;
         for (int k = 0; k < 8; k++) m_hist[i][k] = 3'b000;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int ht, vt;
         ht = g_ha[i] + g_hf[i] + g_hs[i] + g_hb[i];
         vt = g_va[i] + g_vf[i] + g_vs[i] + g_vb[i];
         for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
         m_hist[i][0] = raw_of(i);
         if (m_col[i] == ht - 1) begin
            m_col[i] = 0;
            if (m_row[i] == vt - 1) begin
               m_row[i] = 0;
               m_fc[i]  = (m_fc[i] + 1) % 256;
            end else begin
               m_row[i] = m_row[i] + 1;
            end
         end else begin
            m_col[i] = m_col[i] + 1;
         end
      end
   endtask

   function automatic obs_t model_obs(int i, bit e, bit r);
      obs_t       o;
      logic [2:0] h;
      h     = m_hist[i][g_dly[i]-1];
      o.col = 10'(m_col[i]);
      o.row = 10'(m_row[i]);
      o.hs  = h[2] ? g_hp[i] : ~g_hp[i];
      o.vs  = h[1] ? g_vp[i] : ~g_vp[i];
      o.vld = h[0];
      o.ls  = r && e && (m_col[i] == 0);
      o.fs  = o.ls && (m_row[i] == 0);
      o.fc  = 8'(m_fc[i]);
      return o;
   endfunction

   function automatic obs_t dut_obs(int i);
      obs_t o;
      o.col = col_q[i];
      o.row = row_q[i];
      o.hs  = hs_q[i];
      o.vs  = vs_q[i];
      o.vld = vld_q[i];
      o.ls  = ls_q[i];
      o.fs  = fs_q[i];
      o.fc  = fc_q[i];
      return o;
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick(input bit e_next, input bit r_next);
      @(posedge clk);
      if (rst_n && en) model_step();
      #1;
      en    = e_next;
      rst_n = r_next;
      if (!r_next) model_reset();
      for (int i = 0; i < 3; i++) sb_q.push_back(model_obs(i, e_next, r_next));
   endtask

   task automatic expect_d(input logic [7:0] tag, input int val);
      dq.push_back({tag, 32'(val)});
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      model_reset();
      repeat (3) tick(1'b1, 1'b0);
      expect_d(T_A_COL, 0);
      expect_d(T_C_HS, 1);
      expect_d(T_B_HS, 0);
      expect_d(T_B_VS, 0);
      expect_d(T_MARK, 0);

      tick(1'b1, 1'b1);
      expect_d(T_MEAS_ON, 0);
      repeat (97) tick(1'b1, 1'b1);
      expect_d(T_A_VLD_CNT, 32);
      expect_d(T_A_FS_CNT, 1);
      expect_d(T_A_FC, 0);
      expect_d(T_A_COL, 13);
      expect_d(T_A_ROW, 6);
      expect_d(T_B_RISE, 4);
      tick(1'b1, 1'b1);
      expect_d(T_A_FC, 1);
      expect_d(T_A_COL, 0);
      expect_d(T_A_ROW, 0);
      expect_d(T_A_FS_CNT, 2);

      // Freeze raster C in the middle of its hsync pulse.
      repeat (601) tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      expect_d(T_C_COL, 700);
      expect_d(T_C_HS, 0);
      expect_d(T_MEAS_OFF, 0);
      expect_d(T_MARK, 0);
      repeat (19) tick(1'b0, 1'b1);
      expect_d(T_C_COL, 700);
      expect_d(T_C_HS, 0);
      expect_d(T_STRB_CNT, 0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      expect_d(T_C_COL, 701);
      expect_d(T_MEAS_ON, 0);

      repeat (2000) tick(1'b1, 1'b1);

      // Reset in the middle of a C hsync pulse.
      for (int k = 0; k < 1000 && m_col[2] != 700; k++) tick(1'b1, 1'b1);
      expect_d(T_C_HS, 0);
      expect_d(T_MEAS_OFF, 0);
      tick(1'b1, 1'b0);
      expect_d(T_C_HS, 1);
      expect_d(T_C_COL, 0);
      expect_d(T_A_COL, 0);
      repeat (2) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      expect_d(T_MEAS_ON, 0);
      repeat (656) tick(1'b1, 1'b1);
      expect_d(T_C_COL, 656);
      expect_d(T_C_HS, 1);
      tick(1'b1, 1'b1);
      expect_d(T_C_HS, 0);
      expect_d(T_C_ROW, 0);
      repeat (100) tick(1'b1, 1'b1);
      expect_d(T_SB_EMPTY, 0);
      tick(1'b1, 1'b1);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // ---------------- monitor ----------------
   int   cnt_vld_a   = 0;
   int   cnt_fs_a    = 0;
   int   cnt_strb    = 0;
   bit   b_rise_seen = 1'b0;
   int   b_rise_pos  = -1;
   logic b_vld_prev  = 1'b0;
   logic c_hs_prev   = 1'b1;
   bit   meas_on     = 1'b0;
   bit   run_ok      = 1'b0;
   int   run_len     = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      obs_t  e, a;
      dchk_t d;
      if (sb_q.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            e = sb_q.pop_front();
            a = dut_obs(i);
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL sb_dut%0d: got %h expected %h at %0t", i, a, e, $time);
            end
         end
      end

      cnt_vld_a += int'(vld_q[0]);
      cnt_fs_a  += int'(fs_q[0]);
      for (int i = 0; i < 3; i++) cnt_strb += int'(ls_q[i]) + int'(fs_q[i]);
      if (!b_rise_seen && vld_q[1] && !b_vld_prev) begin
         b_rise_seen = 1'b1;
         b_rise_pos  = int'(row_q[1]) * 1024 + int'(col_q[1]);
      end
      b_vld_prev = vld_q[1];

      if (c_hs_prev && !hs_q[2]) begin
         if (meas_on) chk("c_hs_fall_col", int'(col_q[2]), 657);
         run_len = 1;
         run_ok  = meas_on;
      end else if (!hs_q[2]) begin
         run_len++;
      end else if (!c_hs_prev && run_ok) begin
         chk("c_hs_width", run_len, 96);
         run_ok = 1'b0;
      end
      c_hs_prev = hs_q[2];

      while (dq.size() > 0) begin
         d = dq.pop_front();
         case (d.tag)
            T_MARK: begin
               cnt_vld_a   = 0;
               cnt_fs_a    = 0;
               cnt_strb    = 0;
               b_rise_seen = 1'b0;
               b_rise_pos  = -1;
            end
            T_MEAS_ON:   meas_on = 1'b1;
            T_MEAS_OFF: begin
               meas_on = 1'b0;
               run_ok  = 1'b0;
            end
            T_A_COL:     chk("a_col", int'(col_q[0]), int'(d.val));
            T_A_ROW:     chk("a_row", int'(row_q[0]), int'(d.val));
            T_A_FC:      chk("a_frame_count", int'(fc_q[0]), int'(d.val));
            T_A_VLD_CNT: chk("a_valid_cycles", cnt_vld_a, int'(d.val));
            T_A_FS_CNT:  chk("a_frame_start_cnt", cnt_fs_a, int'(d.val));
            T_B_HS:      chk("b_hsync", int'(hs_q[1]), int'(d.val));
            T_B_VS:      chk("b_vsync", int'(vs_q[1]), int'(d.val));
            T_B_RISE:    chk("b_valid_rise_pos", b_rise_pos, int'(d.val));
            T_C_COL:     chk("c_col", int'(col_q[2]), int'(d.val));
            T_C_ROW:     chk("c_row", int'(row_q[2]), int'(d.val));
            T_C_HS:      chk("c_hsync", int'(hs_q[2]), int'(d.val));
            T_STRB_CNT:  chk("strobes_while_frozen", cnt_strb, int'(d.val));
            T_SB_EMPTY:  chk("sb_drained", sb_q.size(), int'(d.val));
            default:     chk("unknown_tag", int'(d.tag), 0);
         endcase
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that replaces the fixed 640x480 timing block feeding pattern_gen. It produces the pixel column/row counters, h/v sync with selectable polarity, the active-video flag, and frame/line strobes. It also provides a configurable sync/valid delay line so that sync stays aligned with a pattern generator of any pipeline depth. It sits between the PLL pixel clock and pattern_gen in the top-level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
PIPE_DLY, 1, register stages applied to hsync/vsync/valid; range 1..8
CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  pixel clock from PLL
reset  in  1  asynchronous, active-low reset
en  in  1  count enable; low freezes all state
col_count  out  CW  current column, 0..H_TOTAL-1
row_count  out  CW  current row, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
valid  out  1  active-video flag
line_start  out  1  one-cycle pulse when col_count==0
frame_start  out  1  one-cycle pulse when col_count==0 and row_count==0; drives pattern_gen screen_reset
frame_count  out  8  frames completed, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset (reset==0, asynchronous):
  - col_count=0, row_count=0, frame_count=0.
  - Every delay-line stage is loaded with hsync=!HS_POL, vsync=!VS_POL, valid=0.
  - line_start=0, frame_start=0.
- Reset release: first rising edge with en=1 advances col_count 0->1.
- Counting (en=1 only): col_count increments every clock.
  - At col_count==H_TOTAL-1: col_count wraps to 0 and row_count increments.
  - At row_count==V_TOTAL-1 on that same wrap: row_count wraps to 0 and frame_count increments, modulo 256.
- en=0: counters, delay line, and frame_count all hold their values; line_start and frame_start are forced to 0.
- Decode, combinational from the counter registers:
  - act = (col<H_ACTIVE) && (row<V_ACTIVE)
  - hs_raw is at active level when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC
  - vs_raw is at active level when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC; this is a whole-line granularity and changes when col wraps to 0
- Delay line: hs_raw, vs_raw and act pass through a PIPE_DLY-deep shift register that advances only when en=1.
  - hsync, vsync and valid at cycle t reflect the counter state PIPE_DLY enabled cycles earlier.
  - All three are registered outputs and glitch-free.
- col_count and row_count are undelayed. pattern_gen with latency PIPE_DLY consumes them, so its RGB lines up with valid.
- line_start and frame_start are combinational from the counter registers and are undelayed.
- Boundary: with default parameters, hsync goes active when col_count transitions 655->656 (plus PIPE_DLY) and stays active for exactly H_SYNC enabled cycles.
- Reset asserted mid-frame: everything returns to reset values immediately. No partial sync pulse may remain on the outputs after reset release.
- Elaboration checks: a parameter error (fatal) is raised if PIPE_DLY is outside 1..8, if any porch or sync parameter is 0, or if H_TOTAL or V_TOTAL exceeds 2^CW.

Decomposition:
- Package vga_pkg:
  - Default 640x480@60 timing constants.
  - Localparam functions for H_TOTAL and V_TOTAL.
  - A packed struct sync_t {hs, vs, act} used by the delay line.
- Sub-module sync_delay:
  - Parametrised by depth.
  - Shift register of sync_t with enable and asynchronous active-low reset to a programmable idle value.
  - Reused later for the pattern_gen pipeline.

Test Plan:
- Bench parameters: tiny timing H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), PIPE_DLY=1, reset released -> col_count sequence 0..13,0; row_count increments on each wrap; frame_start high once every 98 cycles; frame_count increments 0->1 at cycle 98.
- Defaults, full frame -> hsync low for 96 cycles per line at col 656..751 (delayed 1); vsync low during rows 490..491; valid high for exactly 307200 cycles per frame.
- PIPE_DLY=4 -> valid rises 4 cycles after col_count==0, row==0; hsync edges shifted by 4 relative to the PIPE_DLY=1 run.
- HS_POL=1, VS_POL=1 -> sync pulses inverted; idle levels after reset are 0.
- en held low for 20 cycles mid-line -> col_count, hsync and valid frozen; line_start and frame_start stay 0; counting resumes from the same value when en returns high.
- reset asserted mid-hsync pulse -> hsync returns to the idle level immediately (asynchronously); col_count=0; after release the first hsync pulse starts at col 656 of row 0.
